// File: rtl/instr_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, issues one read per cycle into a
// prefetch FIFO and hands {pc,instr} to decode. Optional macro: FETCH_FAULT_EN.
module instr_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h00400000,
  parameter int          DEPTH    = 2,
  parameter logic [31:0] NOP_WORD = 32'h38000000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  output logic        o_mem_read_n,
  output logic [31:0] o_mem_addr,
  input  logic [31:0] i_mem_data,
  output logic        o_id_valid,
  input  logic        i_id_ready,
  output logic [31:0] o_id_instr,
  output logic [31:0] o_id_pc,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  input  logic        i_halt,
  output logic        o_fetch_fault
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

`ifdef FETCH_FAULT_EN
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HALTED, S_FAULT} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HALTED} state_t;
`endif

  state_t      r_state;
  state_t      w_next_state;
  logic [31:0] r_pc;
  logic [31:0] r_pc_q    [DEPTH];
  logic [31:0] r_instr_q [DEPTH];
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;

  logic        w_empty;
  logic        w_full;
  logic        w_redirect;
  logic        w_pop;
  logic        w_issue;
  logic        w_push;
  logic        w_fault_hit;
  logic [31:0] w_redirect_pc;

  assign w_empty       = (r_wr_ptr == r_rd_ptr);
  assign w_full        = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                         (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_redirect_pc = i_redirect_pc & ~32'h0000_0003;

`ifdef FETCH_FAULT_EN
  logic r_fault;
  // A faulted sequencer ignores redirects; only reset brings it back.
  assign w_redirect    = i_redirect && (r_state != S_FAULT);
  assign w_fault_hit   = w_issue && (i_mem_data == 32'hFFFF_FFFF);
  assign o_fetch_fault = r_fault;
`else
  assign w_redirect    = i_redirect;
  assign w_fault_hit   = 1'b0;
  assign o_fetch_fault = 1'b0;
`endif

  assign w_pop  = !w_empty && i_id_ready && !w_redirect;
  assign w_push = w_issue && !w_fault_hit;

  always_comb begin
    w_next_state = r_state;
    w_issue      = 1'b0;
    case (r_state)
      S_IDLE: w_next_state = S_FETCH;
      S_FETCH: begin
        if (w_redirect) begin
          w_next_state = S_FETCH;
        end else if (i_halt) begin
          w_next_state = S_HALTED;
        end else begin
          w_issue = !w_full || w_pop;
`ifdef FETCH_FAULT_EN
          if (w_issue && (i_mem_data == 32'hFFFF_FFFF)) w_next_state = S_FAULT;
`endif
        end
      end
      S_HALTED: if (w_redirect) w_next_state = S_FETCH;
`ifdef FETCH_FAULT_EN
      S_FAULT: w_next_state = S_FAULT;
`endif
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state  <= S_IDLE;
      r_pc     <= RESET_PC;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_redirect) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_pc     <= w_redirect_pc;
      end else begin
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + PTR_ONE;
          r_pc     <= r_pc + 32'd4;
        end
        if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
    end
  end

`ifdef FETCH_FAULT_EN
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)          r_fault <= 1'b0;
    else if (w_fault_hit) r_fault <= 1'b1;
  end
`endif

  // Payload storage carries no reset; validity comes from the pointers.
  always_ff @(posedge i_clk) begin
    if (w_push && !w_redirect) begin
      r_pc_q[r_wr_ptr[AW-1:0]]    <= r_pc;
      r_instr_q[r_wr_ptr[AW-1:0]] <= i_mem_data;
    end
  end

  assign o_mem_read_n = !w_issue;
  assign o_mem_addr   = r_pc;
  assign o_id_valid   = !w_empty;
  assign o_id_instr   = w_empty ? NOP_WORD : r_instr_q[r_rd_ptr[AW-1:0]];
  assign o_id_pc      = w_empty ? r_pc : r_pc_q[r_rd_ptr[AW-1:0]];

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed bench for instr_fetch_ctrl: cycle table for fetch/stall/redirect/halt,
// then hand sequences for PC wrap, async reset mid-stall and the unmapped word.
module tb_instr_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read_n;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        fetch_fault;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] NOP = 32'h38000000;

  always #5 clk = ~clk;

  // Memory image: nop at the reset vector, unmapped word at 00400088.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h00400000) return 32'h38000000;
    if (a == 32'h00400088) return 32'hFFFFFFFF;
    return {8'hC0, a[23:0]};
  endfunction

  assign mem_data = mem_word(mem_addr);

  instr_fetch_ctrl dut (
    .i_clk         (clk),
    .i_reset       (reset),
    .o_mem_read_n  (mem_read_n),
    .o_mem_addr    (mem_addr),
    .i_mem_data    (mem_data),
    .o_id_valid    (id_valid),
    .i_id_ready    (id_ready),
    .o_id_instr    (id_instr),
    .o_id_pc       (id_pc),
    .i_redirect    (redirect),
    .i_redirect_pc (redirect_pc),
    .i_halt        (halt),
    .o_fetch_fault (fetch_fault)
  );

  typedef struct {
    logic        rdy;
    logic        redir;
    logic [31:0] rpc;
    logic        hlt;
    logic        exp_rn;
    logic [31:0] exp_addr;
    logic        exp_v;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs [20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic rdy, input logic redir, input logic [31:0] rpc, input logic hlt);
    @(negedge clk);
    id_ready    = rdy;
    redirect    = redir;
    redirect_pc = rpc;
    halt        = hlt;
    #1;
  endtask

  task automatic chk_out(input string tag, input logic rn, input logic [31:0] addr,
                         input logic v, input logic [31:0] pc);
    chk({tag, "_rn"},    {31'd0, mem_read_n}, {31'd0, rn});
    chk({tag, "_addr"},  mem_addr, addr);
    chk({tag, "_valid"}, {31'd0, id_valid}, {31'd0, v});
    chk({tag, "_pc"},    id_pc, pc);
    chk({tag, "_instr"}, id_instr, v ? mem_word(pc) : NOP);
  endtask

  initial begin
    //          rdy redir rpc            halt  rn  addr           v   id_pc
    vecs[0]  = '{1, 0, 32'h0,        0,   1, 32'h00400000, 0, 32'h00400000};
    vecs[1]  = '{1, 0, 32'h0,        0,   0, 32'h00400000, 0, 32'h00400000};
    vecs[2]  = '{1, 0, 32'h0,        0,   0, 32'h00400004, 1, 32'h00400000};
    vecs[3]  = '{0, 0, 32'h0,        0,   0, 32'h00400008, 1, 32'h00400004};
    vecs[4]  = '{0, 0, 32'h0,        0,   1, 32'h0040000C, 1, 32'h00400004};
    vecs[5]  = '{0, 0, 32'h0,        0,   1, 32'h0040000C, 1, 32'h00400004};
    vecs[6]  = '{0, 0, 32'h0,        0,   1, 32'h0040000C, 1, 32'h00400004};
    vecs[7]  = '{0, 0, 32'h0,        0,   1, 32'h0040000C, 1, 32'h00400004};
    vecs[8]  = '{1, 0, 32'h0,        0,   0, 32'h0040000C, 1, 32'h00400004};
    vecs[9]  = '{1, 0, 32'h0,        0,   0, 32'h00400010, 1, 32'h00400008};
    vecs[10] = '{1, 1, 32'h00400073, 0,   1, 32'h00400014, 1, 32'h0040000C};
    vecs[11] = '{1, 0, 32'h0,        0,   0, 32'h00400070, 0, 32'h00400070};
    vecs[12] = '{0, 0, 32'h0,        0,   0, 32'h00400074, 1, 32'h00400070};
    vecs[13] = '{1, 0, 32'h0,        1,   1, 32'h00400078, 1, 32'h00400070};
    vecs[14] = '{1, 0, 32'h0,        1,   1, 32'h00400078, 1, 32'h00400074};
    vecs[15] = '{1, 0, 32'h0,        1,   1, 32'h00400078, 0, 32'h00400078};
    vecs[16] = '{1, 0, 32'h0,        1,   1, 32'h00400078, 0, 32'h00400078};
    vecs[17] = '{1, 1, 32'h00400080, 0,   1, 32'h00400078, 0, 32'h00400078};
    vecs[18] = '{1, 0, 32'h0,        0,   0, 32'h00400080, 0, 32'h00400080};
    vecs[19] = '{1, 0, 32'h0,        0,   0, 32'h00400084, 1, 32'h00400080};

    reset = 1'b1; id_ready = 1'b1; redirect = 1'b0; redirect_pc = '0; halt = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk_out("rst", 1'b1, 32'h00400000, 1'b0, 32'h00400000);
    chk("rst_fault", {31'd0, fetch_fault}, 32'd0);
    @(posedge clk); #1 reset = 1'b0;

    for (int i = 0; i < 20; i++) begin
      step(vecs[i].rdy, vecs[i].redir, vecs[i].rpc, vecs[i].hlt);
      chk_out($sformatf("v%0d", i), vecs[i].exp_rn, vecs[i].exp_addr, vecs[i].exp_v, vecs[i].exp_pc);
      chk($sformatf("v%0d_fault", i), {31'd0, fetch_fault}, 32'd0);
    end

    // PC wrap; low redirect bits are dropped
    step(1, 1, 32'hFFFFFFFE, 0);
    chk("wrap0_rn", {31'd0, mem_read_n}, 32'd1);
    step(1, 0, 32'h0, 0);
    chk_out("wrap1", 1'b0, 32'hFFFFFFFC, 1'b0, 32'hFFFFFFFC);
    step(0, 0, 32'h0, 0);
    chk_out("wrap2", 1'b0, 32'h00000000, 1'b1, 32'hFFFFFFFC);
    step(0, 0, 32'h0, 0);
    chk_out("stall_full", 1'b1, 32'h00000004, 1'b1, 32'hFFFFFFFC);

    // Asynchronous reset with two entries queued
    @(negedge clk); reset = 1'b1; #1;
    chk_out("arst", 1'b1, 32'h00400000, 1'b0, 32'h00400000);
    @(posedge clk); #1 reset = 1'b0;
    step(1, 0, 32'h0, 0);
    chk_out("rel0", 1'b1, 32'h00400000, 1'b0, 32'h00400000);
    step(1, 0, 32'h0, 0);
    chk_out("rel1", 1'b0, 32'h00400000, 1'b0, 32'h00400000);
    step(1, 0, 32'h0, 0);
    chk_out("rel2", 1'b0, 32'h00400004, 1'b1, 32'h00400000);

    // Unmapped word at 00400088
    step(1, 1, 32'h00400088, 0);
    chk("flt0_rn", {31'd0, mem_read_n}, 32'd1);
    step(1, 0, 32'h0, 0);
    chk_out("flt1", 1'b0, 32'h00400088, 1'b0, 32'h00400088);
    step(1, 0, 32'h0, 0);
`ifdef FETCH_FAULT_EN
    chk_out("flt2", 1'b1, 32'h00400088, 1'b0, 32'h00400088);
    chk("flt2_fault", {31'd0, fetch_fault}, 32'd1);
    step(1, 0, 32'h0, 0);
    chk_out("flt3", 1'b1, 32'h00400088, 1'b0, 32'h00400088);
    chk("flt3_fault", {31'd0, fetch_fault}, 32'd1);
`else
    chk_out("flt2", 1'b0, 32'h0040008C, 1'b1, 32'h00400088);
    chk("flt2_fault", {31'd0, fetch_fault}, 32'd0);
    step(1, 0, 32'h0, 0);
    chk_out("flt3", 1'b0, 32'h00400090, 1'b1, 32'h0040008C);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
